// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// controller states and the default datapath width.
package mdu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULU = 2'd0,
    OP_MUL  = 2'd1,
    OP_DIVU = 2'd2,
    OP_DIV  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the datapath: shift-add for multiply on {hi,lo},
// restoring shift-subtract for divide with remainder in hi and quotient in lo.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic           fits;

  always_comb begin
    sum    = {1'b0, hi_in} + {1'b0, opnd};
    rem_sh = {hi_in, lo_in[WIDTH-1]};
    diff   = rem_sh - {1'b0, opnd};
    fits   = (rem_sh >= {1'b0, opnd});
    hi_out = hi_in;
    lo_out = lo_in;
    if (div_mode) begin
      // Remainder stays below the divisor, so a successful trial always fits in WIDTH bits.
      hi_out = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      lo_out = {lo_in[WIDTH-2:0], fits};
    end else if (lo_in[0]) begin
      hi_out = sum[WIDTH:1];
      lo_out = {sum[0], lo_in[WIDTH-1:1]};
    end else begin
      hi_out = {1'b0, hi_in[WIDTH-1:1]};
      lo_out = {hi_in[0], lo_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Sequential multiply/divide unit: operands are reduced to magnitudes on
// acceptance, iterated WIDTH cycles, sign-corrected once, then published.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             bzero_q, bzero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_neg;
  logic               in_signed;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (op_is_div(op_q)),
    .hi_in    (acc_hi_q),
    .lo_in    (acc_lo_q),
    .opnd     (opnd_q),
    .hi_out   (step_hi),
    .lo_out   (step_lo)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_CALC;
      ST_CALC: if (cnt_q == CW'(WIDTH - 1)) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output logic
  always_comb begin
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    a_d       = a_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;
    in_signed = op_is_signed(op_e'(Op));
    mag_a     = (in_signed && A[WIDTH-1]) ? -A : A;
    mag_b     = (in_signed && B[WIDTH-1]) ? -B : B;
    prod_neg  = -{acc_hi_q, acc_lo_q};

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d      = op_e'(Op);
          cnt_d     = '0;
          a_d       = A;
          acc_hi_d  = '0;
          neg_res_d = in_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
          neg_rem_d = in_signed && A[WIDTH-1];
          bzero_d   = (B == '0);
          // Multiply iterates over the multiplier in lo; divide shifts the dividend out of lo.
          acc_lo_d  = op_is_div(op_e'(Op)) ? mag_a : mag_b;
          opnd_d    = op_is_div(op_e'(Op)) ? mag_b : mag_a;
        end
      end
      ST_CALC: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + CW'(1);
      end
      ST_FIX: begin
        if (!op_is_div(op_q)) begin
          if (neg_res_q) {acc_hi_d, acc_lo_d} = prod_neg;
        end else if (bzero_q) begin
          acc_hi_d = a_q;
          acc_lo_d = '1;
        end else begin
          if (neg_res_q) acc_lo_d = -acc_lo_q;
          if (neg_rem_q) acc_hi_d = -acc_hi_q;
        end
      end
      default: ;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_DONE);
    hi_d   = (state_q == ST_DONE) ? acc_hi_q : hi_q;
    lo_d   = (state_q == ST_DONE) ? acc_lo_q : lo_q;
    zero_d = (state_q == ST_DONE) ? (acc_lo_q == '0) : zero_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_MULU;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      a_q       <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      zero_q    <= 1'b1;
    end else begin
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      a_q       <= a_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      bzero_q   <= bzero_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      zero_q    <= zero_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;
  assign Zero = zero_q;

endmodule
